// File: rtl/clock_op_scheduler_if.sv
// Request, acknowledge and operation bus shared by input conditioning, scheduler and mm:ss counter.
interface clock_op_scheduler_if #(
  parameter int unsigned CNT_W = 4
);
  logic             req_madd;
  logic             req_szero;
  logic             req_reset;
  logic             ack_in;
  logic [1:0]       operation;
  logic             busy;
  logic [CNT_W-1:0] pending_madd;
  logic             op_done;
  logic             timeout_err;

  modport master (
    output req_madd, req_szero, req_reset, ack_in,
    input  operation, busy, pending_madd, op_done, timeout_err
  );

  modport slave (
    input  req_madd, req_szero, req_reset, ack_in,
    output operation, busy, pending_madd, op_done, timeout_err
  );
endinterface

// File: rtl/clock_op_scheduler.sv
// Serialises minute-add / seconds-zero / clock-reset requests onto the counter's
// 2-bit operation bus: one-cycle issue, wait for acknowledge, then a quiet gap.
module clock_op_scheduler #(
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter int unsigned ACK_TIMEOUT = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  clock_op_scheduler_if.slave bus
);
  localparam int unsigned      TMR_W    = 8;
  localparam logic [CNT_W-1:0] MADD_MAX = {CNT_W{1'b1}};
  localparam logic [TMR_W-1:0] ACK_LAST = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(GAP_CYCLES - 1);

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_SZERO = 2'b01;
  localparam logic [1:0] OP_MADD  = 2'b10;
  localparam logic [1:0] OP_RESET = 2'b11;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, GAP} state_t;

  state_t           state, state_d;
  logic [TMR_W-1:0] timer, timer_d;
  logic [1:0]       operation_q, operation_d;
  logic             busy_q, busy_d;
  logic             op_done_q, op_done_d;
  logic             timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0] madd_q, madd_d;
  logic             szero_q, szero_d;
  logic             reset_q, reset_d;
  logic             take_madd, take_szero, take_reset;

  assign bus.operation    = operation_q;
  assign bus.busy         = busy_q;
  assign bus.pending_madd = madd_q;
  assign bus.op_done      = op_done_q;
  assign bus.timeout_err  = timeout_err_q;

  // Next state, arbitration and registered-output values
  always_comb begin
    state_d       = state;
    timer_d       = timer;
    operation_d   = OP_NONE;
    op_done_d     = 1'b0;
    timeout_err_d = timeout_err_q;
    take_madd     = 1'b0;
    take_szero    = 1'b0;
    take_reset    = 1'b0;
    unique case (state)
      IDLE: begin
        if (reset_q) begin
          take_reset  = 1'b1;
          operation_d = OP_RESET;
          state_d     = ISSUE;
        end else if (szero_q) begin
          take_szero  = 1'b1;
          operation_d = OP_SZERO;
          state_d     = ISSUE;
        end else if (madd_q != '0) begin
          take_madd   = 1'b1;
          operation_d = OP_MADD;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT_ACK;
        timer_d = '0;
      end
      WAIT_ACK: begin
        if (bus.ack_in) begin
          op_done_d = 1'b1;
          state_d   = GAP;
          timer_d   = '0;
        end else if (timer == ACK_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = GAP;
          timer_d       = '0;
        end else begin
          timer_d = timer + TMR_W'(1);
        end
      end
      GAP: begin
        // Gap length is a minimum; a still-high ack keeps us here
        if (timer == GAP_LAST) begin
          if (!bus.ack_in) state_d = IDLE;
        end else begin
          timer_d = timer + TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Request latches: a new pulse always wins over a same-cycle consume
  always_comb begin
    reset_d = (reset_q & ~take_reset) | bus.req_reset;
    szero_d = (szero_q & ~take_szero & ~take_reset) | bus.req_szero;
    if (take_reset) begin
      madd_d = bus.req_madd ? CNT_W'(1) : '0;
    end else if (bus.req_madd && take_madd) begin
      madd_d = madd_q;
    end else if (bus.req_madd && (madd_q != MADD_MAX)) begin
      madd_d = madd_q + CNT_W'(1);
    end else if (take_madd) begin
      madd_d = madd_q - CNT_W'(1);
    end else begin
      madd_d = madd_q;
    end
  end

  // State, timer, request latches and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      timer         <= '0;
      operation_q   <= OP_NONE;
      busy_q        <= 1'b0;
      op_done_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      madd_q        <= '0;
      szero_q       <= 1'b0;
      reset_q       <= 1'b0;
    end else begin
      state         <= state_d;
      timer         <= timer_d;
      operation_q   <= operation_d;
      busy_q        <= busy_d;
      op_done_q     <= op_done_d;
      timeout_err_q <= timeout_err_d;
      madd_q        <= madd_d;
      szero_q       <= szero_d;
      reset_q       <= reset_d;
    end
  end
endmodule
